// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit combinational alu: queues (a, b, op) requests in a FIFO,
// drives one at a time onto registered alu inputs and returns each result with its opcode.
//
// state | meaning
// IDLE  | no request in flight; pop the FIFO head as soon as one is queued
// DRIVE | alu_*_o settled for one cycle; capture alu_res_i at the next edge
// HOLD  | response valid; wait for rsp_ready_i, then pop the next head or go idle
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [DATA_W-1:0]        req_a_i,
  input  logic [DATA_W-1:0]        req_b_i,
  input  logic [OP_W-1:0]          req_op_i,
  output logic [DATA_W-1:0]        alu_a_o,
  output logic [DATA_W-1:0]        alu_b_o,
  output logic [OP_W-1:0]          alu_op_o,
  input  logic [DATA_W-1:0]        alu_res_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_W-1:0]        rsp_res_o,
  output logic [OP_W-1:0]          rsp_op_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [DATA_W-1:0] r_mem_a  [DEPTH];
  logic [DATA_W-1:0] r_mem_b  [DEPTH];
  logic [OP_W-1:0]   r_mem_op [DEPTH];

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_res;
  logic [OP_W-1:0]   r_rsp_op;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_state_nxt;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
  assign w_push  = req_valid_i && !w_full;
  assign w_pop   = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_HOLD) && rsp_ready_i));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_DRIVE;
      S_DRIVE: w_state_nxt = S_HOLD;
      S_HOLD:  if (rsp_ready_i) w_state_nxt = w_empty ? S_IDLE : S_DRIVE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= req_a_i;
      r_mem_b[r_wr_ptr]  <= req_b_i;
      r_mem_op[r_wr_ptr] <= req_op_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_op    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_alu_a  <= r_mem_a[r_rd_ptr];
        r_alu_b  <= r_mem_b[r_rd_ptr];
        r_alu_op <= r_mem_op[r_rd_ptr];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (r_state == S_DRIVE) begin
        r_rsp_res   <= alu_res_i;
        r_rsp_op    <= r_alu_op;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == S_HOLD) && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready_o = !w_full;
  assign alu_a_o     = r_alu_a;
  assign alu_b_o     = r_alu_b;
  assign alu_op_o    = r_alu_op;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_res_o   = r_rsp_res;
  assign rsp_op_o    = r_rsp_op;
  assign count_o     = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random checks for alu_op_sequencer; a local alu model closes the loop
// and a queue scoreboard holds expected {result, op} for every accepted request.
module tb_alu_op_sequencer;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [DATA_W-1:0] req_a_i;
  logic [DATA_W-1:0] req_b_i;
  logic [OP_W-1:0]   req_op_i;
  logic [DATA_W-1:0] alu_a_o;
  logic [DATA_W-1:0] alu_b_o;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_res_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_res_o;
  logic [OP_W-1:0]   rsp_op_o;
  logic [CW-1:0]     count_o;

  int n_vec  = 0;
  int n_err  = 0;
  int n_rsp  = 0;
  int n_push = 0;
  logic [DATA_W+OP_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [OP_W-1:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res_i = alu_f(alu_a_o, alu_b_o, alu_op_o);

  alu_op_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_op_o(rsp_op_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; samples the handshakes that
  // the coming rising edge will perform, then returns at the next falling edge.
  task automatic tick();
    logic [DATA_W+OP_W-1:0] e;
    #1;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (req_valid_i && req_ready_o) begin
        exp_q.push_back({alu_f(req_a_i, req_b_i, req_op_i), req_op_i});
        n_push++;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        n_rsp++;
        chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_res", 32'(rsp_res_o), 32'(e[DATA_W+OP_W-1:OP_W]));
          chk("rsp_op", 32'(rsp_op_o), 32'(e[OP_W-1:0]));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    while (((count_o != 0) || rsp_valid_o || (exp_q.size() != 0)) && (cyc < 60)) begin
      tick();
      cyc++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int p_rsp;
    int p_push;
    int sent;
    int cyc;

    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_a_i = '0;
    req_b_i = '0;
    req_op_i = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_res", 32'(rsp_res_o), 32'd0);
    chk("rst_alu_a", 32'(alu_a_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;
    tick();

    // single request: latency and one response only
    p_rsp = n_rsp;
    req_valid_i = 1'b1; req_a_i = 8'd50; req_b_i = 8'd3; req_op_i = 3'd0;
    rsp_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk("t1_count", 32'(count_o), 32'd1);
    tick();
    chk("t1_alu_a", 32'(alu_a_o), 32'd50);
    chk("t1_alu_b", 32'(alu_b_o), 32'd3);
    chk("t1_early_valid", 32'(rsp_valid_o), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid_o), 32'd1);
    chk("t1_res", 32'(rsp_res_o), 32'd53);
    chk("t1_op", 32'(rsp_op_o), 32'd0);
    repeat (5) tick();
    chk("t1_one_rsp", 32'(n_rsp - p_rsp), 32'd1);
    chk("t1_idle_valid", 32'(rsp_valid_o), 32'd0);

    // fill under backpressure: one request goes to the alu, four fill the FIFO
    p_rsp = n_rsp;
    p_push = n_push;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid_i = 1'b1; req_a_i = 8'd50; req_b_i = 8'd3; req_op_i = 3'(i);
      tick();
    end
    req_valid_i = 1'b0;
    chk("t2_full_count", 32'(count_o), 32'd4);
    chk("t2_full_ready", 32'(req_ready_o), 32'd0);
    chk("t2_accepted", 32'(n_push - p_push), 32'd5);

    // hold: response and alu inputs must not move while rsp_ready_i is low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("t4_hold_res", 32'(rsp_res_o), 32'd53);
      chk("t4_hold_op", 32'(rsp_op_o), 32'd0);
      chk("t4_hold_alu_op", 32'(alu_op_o), 32'd0);
      chk("t4_hold_alu_a", 32'(alu_a_o), 32'd50);
    end

    // full FIFO, pop and push offered together: push refused, then accepted
    p_push = n_push;
    req_valid_i = 1'b1; req_a_i = 8'd7; req_b_i = 8'd9; req_op_i = 3'd6;
    rsp_ready_i = 1'b1;
    tick();
    chk("t3_pop_count", 32'(count_o), 32'd3);
    chk("t3_push_refused", 32'(n_push - p_push), 32'd0);
    chk("t3_valid_drop", 32'(rsp_valid_o), 32'd0);
    chk("t3_alu_op_next", 32'(alu_op_o), 32'd1);
    rsp_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    chk("t3_push_count", 32'(count_o), 32'd4);
    chk("t3_push_taken", 32'(n_push - p_push), 32'd1);
    chk("t4_release_valid", 32'(rsp_valid_o), 32'd1);
    chk("t4_release_res", 32'(rsp_res_o), 32'd47);
    chk("t4_release_op", 32'(rsp_op_o), 32'd1);
    drain("t2_drain");
    chk("t2_rsp_total", 32'(n_rsp - p_rsp), 32'd6);

    // reset while in DRIVE with three queued
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1; req_a_i = 8'(10 + i); req_b_i = 8'd4; req_op_i = 3'(i);
      tick();
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    chk("t5_pre_count", 32'(count_o), 32'd3);
    chk("t5_pre_drive", 32'(rsp_valid_o), 32'd0);
    rsp_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_valid", 32'(rsp_valid_o), 32'd0);
    chk("t5_res", 32'(rsp_res_o), 32'd0);
    chk("t5_rsp_op", 32'(rsp_op_o), 32'd0);
    chk("t5_alu", 32'({alu_a_o, alu_b_o, alu_op_o}), 32'd0);
    p_rsp = n_rsp;
    rsp_ready_i = 1'b1;
    repeat (8) tick();
    chk("t5_no_rsp", 32'(n_rsp - p_rsp), 32'd0);
    chk("t5_still_empty", 32'(count_o), 32'd0);

    // random stream with random response backpressure
    p_rsp = n_rsp;
    sent = 0;
    cyc = 0;
    req_a_i = 8'($urandom); req_b_i = 8'($urandom); req_op_i = 3'($urandom_range(0, 7));
    while ((sent < 10) && (cyc < 300)) begin
      req_valid_i = 1'b1;
      rsp_ready_i = 1'($urandom_range(0, 1));
      p_push = n_push;
      tick();
      if (n_push != p_push) begin
        sent++;
        req_a_i = 8'($urandom); req_b_i = 8'($urandom); req_op_i = 3'($urandom_range(0, 7));
      end
      chk("t6_count_le_depth", 32'(count_o <= 3'(DEPTH)), 32'd1);
      cyc++;
    end
    req_valid_i = 1'b0;
    chk("t6_all_sent", 32'(sent), 32'd10);
    drain("t6_drain");
    chk("t6_rsp_total", 32'(n_rsp - p_rsp), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
